// File: rtl/rx_cmd_parser_if.sv
// rx_cmd_parser_if: RX bit stream in, decoded command strobes out.
// The RX demodulator side is master; the parser is slave.
interface rx_cmd_parser_if;
   logic        bitin;
   logic        bitclk;
   logic        frame_reset;
   logic        cmd_valid;
   logic [2:0]  cmd_code;
   logic [15:0] payload;
   logic        crc_ok;
   logic        cmd_err;

   modport master (
      output bitin, bitclk, frame_reset,
      input  cmd_valid, cmd_code, payload, crc_ok, cmd_err
   );

   modport slave (
      input  bitin, bitclk, frame_reset,
      output cmd_valid, cmd_code, payload, crc_ok, cmd_err
   );
endinterface

// File: rtl/rx_cmd_parser.sv
// rx_cmd_parser: frames Gen2 RX bits into commands, checks CRC-5/CRC-16.
// Define REQRN_EN to decode ReqRN and build the CRC-16 checker.
module rx_cmd_parser #(
   parameter logic [4:0]  CRC5_PRESET   = 5'b01001,
   parameter logic [15:0] CRC16_PRESET  = 16'hFFFF,
   parameter logic [15:0] CRC16_RESIDUE = 16'h1D0F
) (
   input logic            clk,
   input logic            reset,
   rx_cmd_parser_if.slave bus
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PAY  = 3'd1;
   localparam logic [2:0] S_CRC  = 3'd2;
   localparam logic [2:0] S_DONE = 3'd3;
   localparam logic [2:0] S_IGN  = 3'd4;

   localparam logic [2:0] C_QREP  = 3'd0;
   localparam logic [2:0] C_ACK   = 3'd1;
   localparam logic [2:0] C_QUERY = 3'd2;
   localparam logic [2:0] C_QADJ  = 3'd3;
   localparam logic [2:0] C_NAK   = 3'd5;
`ifdef REQRN_EN
   localparam logic [2:0] C_REQRN = 3'd4;
`endif

   logic [2:0]  state;
   logic        bitclk_d;
   logic [5:0]  cnt;
   logic [5:0]  total;
   logic [4:0]  pcnt;
   logic [4:0]  plen;
   logic [6:0]  opc;
   logic [15:0] sr;
   logic [2:0]  code;
   logic [4:0]  crc5;

   logic        valid_q;
   logic        err_q;
   logic        crc_ok_q;
   logic [2:0]  code_q;
   logic [15:0] pay_q;

   logic        ev;
   logic        b;
   logic        active;
   logic [5:0]  cnt_n;
   logic [7:0]  opc_n;
   logic [4:0]  crc5_n;
   logic [4:0]  pcnt_n;
   logic [15:0] sr_n;
   logic        shift_en;
   logic        fin;
   logic        crc_ok_n;
   logic        dec_hit;
   logic        dec_err;
   logic [2:0]  dec_code;
   logic [4:0]  dec_plen;
   logic [5:0]  dec_total;
   logic [2:0]  code_c;
   logic [5:0]  total_c;

   assign b        = bus.bitin;
   assign ev       = bus.bitclk & ~bitclk_d;
   assign active   = (state == S_IDLE) || (state == S_PAY) || (state == S_CRC);
   assign cnt_n    = (&cnt) ? cnt : cnt + 6'd1;
   assign opc_n    = {opc, b};
   assign crc5_n   = {crc5[3:0], 1'b0} ^ ({5{b ^ crc5[4]}} & 5'b01001);
   assign shift_en = (state == S_PAY) && (pcnt < plen);
   assign sr_n     = shift_en ? {sr[14:0], b} : sr;
   assign pcnt_n   = shift_en ? pcnt + 5'd1 : pcnt;
   assign code_c   = (state == S_IDLE) ? dec_code : code;
   assign total_c  = (state == S_IDLE) ? dec_total : total;
   assign fin      = ev && active && ((state != S_IDLE) || dec_hit)
                     && (cnt_n == total_c);

`ifdef REQRN_EN
   logic [15:0] crc16;
   logic [15:0] crc16_n;

   assign crc16_n = {crc16[14:0], 1'b0} ^ ({16{b ^ crc16[15]}} & 16'h1021);

   always_ff @(posedge clk or negedge reset)
      if (!reset)
         crc16 <= CRC16_PRESET;
      else if (bus.frame_reset)
         crc16 <= CRC16_PRESET;
      else if (ev && active)
         crc16 <= crc16_n;
`else
   logic unused_crc16;
   assign unused_crc16 = ^{CRC16_PRESET, CRC16_RESIDUE};
`endif

   // Opcode tree: decided at 2, 4 or 8 received bits.
   always_comb begin
      dec_hit   = 1'b0;
      dec_err   = 1'b0;
      dec_code  = C_QREP;
      dec_plen  = 5'd0;
      dec_total = 6'd0;
      unique case (1'b1)
         (cnt_n == 6'd2) && !opc_n[1]: begin
            dec_hit   = 1'b1;
            dec_code  = opc_n[0] ? C_ACK : C_QREP;
            dec_plen  = opc_n[0] ? 5'd16 : 5'd2;
            dec_total = opc_n[0] ? 6'd18 : 6'd4;
         end
         (cnt_n == 6'd4) && (opc_n[3:2] == 2'b10): begin
            if (opc_n[1]) begin
               dec_err = 1'b1;
            end else begin
               dec_hit   = 1'b1;
               dec_code  = opc_n[0] ? C_QADJ : C_QUERY;
               dec_plen  = opc_n[0] ? 5'd5 : 5'd13;
               dec_total = opc_n[0] ? 6'd9 : 6'd22;
            end
         end
         (cnt_n == 6'd8): begin
            if (opc_n == 8'hC0) begin
               dec_hit   = 1'b1;
               dec_code  = C_NAK;
               dec_total = 6'd8;
`ifdef REQRN_EN
            end else if (opc_n == 8'hC1) begin
               dec_hit   = 1'b1;
               dec_code  = C_REQRN;
               dec_plen  = 5'd16;
               dec_total = 6'd40;
`endif
            end else begin
               dec_err = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      crc_ok_n = 1'b1;
      if (code_c == C_QUERY)
         crc_ok_n = (crc5_n == 5'd0);
`ifdef REQRN_EN
      if (code_c == C_REQRN)
         crc_ok_n = (crc16_n == CRC16_RESIDUE);
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         bitclk_d <= 1'b0;
         cnt      <= 6'd0;
         total    <= 6'd0;
         pcnt     <= 5'd0;
         plen     <= 5'd0;
         opc      <= 7'd0;
         sr       <= 16'd0;
         code     <= 3'd0;
         crc5     <= CRC5_PRESET;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         crc_ok_q <= 1'b0;
         code_q   <= 3'd0;
         pay_q    <= 16'd0;
      end else begin
         bitclk_d <= bus.bitclk;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         // Abort beats everything, including a final-bit event.
         if (bus.frame_reset) begin
            state <= S_IDLE;
            cnt   <= 6'd0;
            pcnt  <= 5'd0;
            opc   <= 7'd0;
            sr    <= 16'd0;
            crc5  <= CRC5_PRESET;
         end else if (ev && active) begin
            cnt  <= cnt_n;
            crc5 <= crc5_n;
            sr   <= sr_n;
            pcnt <= pcnt_n;
            if (state == S_IDLE) begin
               opc <= opc_n[6:0];
               if (dec_hit) begin
                  code  <= dec_code;
                  plen  <= dec_plen;
                  total <= dec_total;
               end
            end
            if (fin) begin
               state    <= S_DONE;
               valid_q  <= 1'b1;
               code_q   <= code_c;
               pay_q    <= sr_n;
               crc_ok_q <= crc_ok_n;
            end else if ((state == S_IDLE) && dec_err) begin
               state <= S_IGN;
               err_q <= 1'b1;
            end else if ((state == S_IDLE) && dec_hit) begin
               state <= S_PAY;
            end else if (shift_en && (pcnt_n == plen)) begin
               state <= S_CRC;
            end
         end
      end
   end

   assign bus.cmd_valid = valid_q;
   assign bus.cmd_err   = err_q;
   assign bus.cmd_code  = code_q;
   assign bus.payload   = pay_q;
   assign bus.crc_ok    = crc_ok_q;

endmodule

// File: tb/tb_rx_cmd_parser.sv
// tb_rx_cmd_parser: directed frames against rx_cmd_parser.
// Build with +define+REQRN_EN to exercise the ReqRN path.
module tb_rx_cmd_parser;

   logic clk;
   logic reset;
   int   checks;
   int   passed;
   int   nvalid;
   int   nerr;
   int   nboth;
   int   v0;
   int   e0;

   rx_cmd_parser_if bus ();

   rx_cmd_parser dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.cmd_valid) nvalid++;
      if (bus.cmd_err) nerr++;
      if (bus.cmd_valid && bus.cmd_err) nboth++;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic send_bit(input logic b, input int hold);
      @(negedge clk);
      bus.bitin  = b;
      bus.bitclk = 1'b1;
      repeat (hold) @(negedge clk);
      bus.bitclk = 1'b0;
   endtask

   task automatic send_bits(input logic [39:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i], 1);
   endtask

   task automatic abort();
      @(negedge clk);
      bus.frame_reset = 1'b1;
      @(negedge clk);
      bus.frame_reset = 1'b0;
   endtask

   task automatic mark();
      v0 = nvalid;
      e0 = nerr;
   endtask

   task automatic expect_cmd(input string tag, input int nv, input int ne,
                             input logic [2:0] code, input logic [15:0] pay,
                             input logic ok);
      repeat (3) @(negedge clk);
      check({tag, "_nvalid"}, nvalid - v0, nv);
      check({tag, "_nerr"}, nerr - e0, ne);
      check({tag, "_code"}, {29'd0, bus.cmd_code}, {29'd0, code});
      check({tag, "_payload"}, {16'd0, bus.payload}, {16'd0, pay});
      check({tag, "_crc_ok"}, {31'd0, bus.crc_ok}, {31'd0, ok});
   endtask

`ifdef REQRN_EN
   function automatic logic [15:0] crc16_of(input logic [23:0] d);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 23; i >= 0; i--)
         c = {c[14:0], 1'b0} ^ ((d[i] ^ c[15]) ? 16'h1021 : 16'h0000);
      return c;
   endfunction
`endif

   initial begin
      checks = 0;
      passed = 0;
      nvalid = 0;
      nerr = 0;
      nboth = 0;
      bus.bitin = 1'b0;
      bus.bitclk = 1'b0;
      bus.frame_reset = 1'b0;
      reset = 1'b1;
      #3 reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", {31'd0, bus.cmd_valid}, 32'd0);
      check("rst_err", {31'd0, bus.cmd_err}, 32'd0);
      check("rst_code", {29'd0, bus.cmd_code}, 32'd0);
      check("rst_payload", {16'd0, bus.payload}, 32'd0);
      check("rst_crc_ok", {31'd0, bus.crc_ok}, 32'd0);
      reset = 1'b1;

      // QueryRep 0010 with exact strobe timing
      mark();
      send_bits(40'b001, 3);
      @(negedge clk);
      bus.bitin = 1'b0;
      bus.bitclk = 1'b1;
      @(negedge clk);
      check("qrep_strobe", {31'd0, bus.cmd_valid}, 32'd1);
      bus.bitclk = 1'b0;
      @(negedge clk);
      check("qrep_strobe_end", {31'd0, bus.cmd_valid}, 32'd0);
      expect_cmd("qrep", 1, 0, 3'd0, 16'h0002, 1'b1);

      // ACK 01 + A5C3
      abort();
      mark();
      send_bits({22'd0, 2'b01, 16'hA5C3}, 18);
      expect_cmd("ack", 1, 0, 3'd1, 16'hA5C3, 1'b1);

      // reset mid-frame, then QueryRep 0011 without frame_reset
      abort();
      send_bits(40'b01101, 5);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_code", {29'd0, bus.cmd_code}, 32'd0);
      check("midrst_payload", {16'd0, bus.payload}, 32'd0);
      check("midrst_crc_ok", {31'd0, bus.crc_ok}, 32'd0);
      reset = 1'b1;
      mark();
      send_bits(40'b0011, 4);
      expect_cmd("qrep_after_rst", 1, 0, 3'd0, 16'h0003, 1'b1);

      // Query, 13 zero payload bits, good CRC-5 10000
      abort();
      mark();
      send_bits({18'd0, 4'b1000, 13'd0, 5'b10000}, 22);
      expect_cmd("query_ok", 1, 0, 3'd2, 16'h0000, 1'b1);

      // same frame, corrupted last CRC bit
      abort();
      mark();
      send_bits({18'd0, 4'b1000, 13'd0, 5'b10001}, 22);
      expect_cmd("query_bad", 1, 0, 3'd2, 16'h0000, 1'b0);

      // unsupported 1010: error strobe, held outputs untouched
      abort();
      mark();
      send_bits(40'b1010, 4);
      expect_cmd("unsup_1010", 0, 1, 3'd2, 16'h0000, 1'b0);
      mark();
      send_bits(40'h2AD, 10);
      expect_cmd("ignore", 0, 0, 3'd2, 16'h0000, 1'b0);

      // NAK
      abort();
      mark();
      send_bits(40'hC0, 8);
      expect_cmd("nak", 1, 0, 3'd5, 16'h0000, 1'b1);

      abort();
      mark();
`ifdef REQRN_EN
      send_bits({8'hC1, 16'h1234, ~crc16_of({8'hC1, 16'h1234})}, 40);
      expect_cmd("reqrn", 1, 0, 3'd4, 16'h1234, 1'b1);
`else
      send_bits(40'hC1, 8);
      expect_cmd("reqrn_unsup", 0, 1, 3'd5, 16'h0000, 1'b1);
`endif

      // abort partial ACK, then QueryAdjust with first bit held high
      abort();
      mark();
      send_bits(40'b0110100110, 10);
      abort();
      send_bit(1'b1, 4);
      send_bits(40'b00101011, 8);
      expect_cmd("qadj", 1, 0, 3'd3, 16'h000B, 1'b1);

      // frame_reset coincident with final QueryRep bit wins
      abort();
      mark();
      send_bits(40'b000, 3);
      @(negedge clk);
      bus.bitin = 1'b1;
      bus.bitclk = 1'b1;
      bus.frame_reset = 1'b1;
      @(negedge clk);
      bus.bitclk = 1'b0;
      bus.frame_reset = 1'b0;
      expect_cmd("fr_final", 0, 0, 3'd3, 16'h000B, 1'b1);

      check("never_both", nboth, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/rx_cmd_parser.md
Name: rx_cmd_parser

Overview:
Consumes the serial bit stream from the Gen2 RX demodulator (bitout sampled on bitclk rising edges) and frames it into commands. Decodes the opcode tree, captures the payload, and checks CRC-5 or CRC-16. Emits a one-cycle command strobe to the tag state machine. Sits directly downstream of the RX block. Uses the same clk; RX bitclk is treated as a level sampled in this domain.

Parameters:
CRC5_PRESET, 5'b01001, CRC-5 register preset (poly x^5+x^3+1)
CRC16_PRESET, 16'hFFFF, CRC-16 register preset (poly 0x1021)
CRC16_RESIDUE, 16'h1D0F, required CRC-16 register value after the last received bit

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
bitin  in  1  RX serial data, valid at bitclk rising edge
bitclk  in  1  RX bit strobe (level); rising edge = new bit
frame_reset  in  1  RX overflow/end-of-frame; synchronous abort to IDLE
cmd_valid  out  1  one-cycle strobe: command complete
cmd_code  out  3  0 QueryRep, 1 ACK, 2 Query, 3 QueryAdjust, 4 ReqRN, 5 NAK
payload  out  16  post-opcode fields excluding CRC, MSB first, right-justified
crc_ok  out  1  CRC check result; 1 for commands without CRC
cmd_err  out  1  one-cycle strobe: unsupported opcode

Behaviour:
- Reset (reset=0): all outputs 0; state IDLE; bit counter 0; CRC5 = CRC5_PRESET; CRC16 = CRC16_PRESET; bitclk_d = 0.
- Bit event: bitclk & ~bitclk_d, where bitclk_d is a 1-cycle delayed copy. bitin is sampled in the same cycle. A bitclk held high gives exactly one event.
- Each event: increment the 6-bit counter (saturates at 63); update CRC5 and CRC16 serially over every bit, opcode included.
  - fb = bit ^ crc[MSB]; crc = crc<<1; if fb, crc ^= poly.
- States: IDLE(opcode) -> PAYLOAD -> CRC -> DONE; side state IGNORE.
- Opcode decode is evaluated at the event that delivers the deciding bit:
  - 2 bits: 00 -> QueryRep, total 4 bits. 01 -> ACK, total 18 bits.
  - 4 bits: 1000 -> Query, total 22 (13 payload + CRC5). 1001 -> QueryAdjust, total 9. 1010/1011 -> unsupported.
  - 8 bits: 11000001 -> ReqRN, total 40 (16 payload + CRC16). 11000000 -> NAK, total 8. Other 11xxxxxx -> unsupported.
- Payload shifts in only while the payload bit count is below the command's payload length; CRC bits are not shifted into payload. Unused upper payload bits are 0.
- On the event delivering the final bit: next cycle, cmd_valid=1 for exactly one cycle. cmd_code, payload and crc_ok are valid that cycle and held until the next cmd_valid or reset.
  - Query: crc_ok = (CRC5 == 0).
  - ReqRN: crc_ok = (CRC16 == CRC16_RESIDUE).
  - Others: crc_ok = 1.
- Unsupported opcode: next cycle, cmd_err=1 for one cycle; go to IGNORE. cmd_code, payload and crc_ok are unchanged.
- DONE and IGNORE discard further bit events until frame_reset.
- frame_reset=1 in any state, next edge: go to IDLE; clear counter, payload shift register and CRCs to presets; drop any partial command with no strobe. Held outputs (cmd_code, payload, crc_ok) are not cleared.
- frame_reset coincident with a final-bit event: frame_reset wins; no cmd_valid.
- cmd_valid and cmd_err are never high in the same cycle.

Optional Feature:
REQRN_EN: when defined, 11000001 decodes as ReqRN (40 bits, CRC16 check, cmd_code 4). When undefined, the CRC16 logic is removed and 11000001 is treated as unsupported (cmd_err, IGNORE). NAK is decoded in both builds.

Test Plan:
- Reset low mid-frame, release -> all outputs 0; next valid QueryRep decodes normally.
- Bits 0,0,1,0 -> cmd_valid 1 cycle after the 4th event; cmd_code=0; payload=16'h0002; crc_ok=1.
- Bits 01 then 16'hA5C3 MSB first -> cmd_code=1; payload=16'hA5C3; crc_ok=1.
- Query 1000 + 13 zeros + CRC 10000 -> cmd_code=2, payload=0, crc_ok=1. Same frame with last bit 1 -> crc_ok=0.
- Bits 1,0,1,0 -> cmd_err pulse; 10 more events produce no strobes; frame_reset, then 11000000 -> cmd_code=5.
- frame_reset asserted after 10 ACK bits, then full QueryAdjust 1001_01_011 -> only one cmd_valid; cmd_code=3; payload=16'h000B.
